// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter
//   Shares one barrier gate between the entry and exit lanes of the lot and
//   owns the regular / handicap free-space pools. One vehicle is served at a
//   time through an OPENING -> WAIT_PASS -> CLOSING cycle. Pool counts change
//   only when pass_sensor confirms that the vehicle has cleared the gate.
//
// Ports
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   entry_req, entry_hc   entry vehicle present / holds a handicap permit
//   exit_req, exit_hc     exit vehicle present / was parked in the handicap pool
//   pass_sensor           1-cycle pulse: vehicle cleared the gate
//   gate_open             motor drive, 1 = open / hold open
//   entry_grant           1-cycle pulse: entry transaction started
//   exit_grant            1-cycle pulse: exit transaction started
//   entry_deny            1-cycle pulse: no space in any eligible pool
//   timeout               1-cycle pulse: no pass seen, transaction aborted
//   reg_free, hc_free     free-space counters
//   lot_full              both pools empty
//   busy                  a transaction is in flight
module parking_gate_arbiter #(
    parameter int REG_SPACES   = 20,
    parameter int HC_SPACES    = 5,
    parameter int CNT_W        = 5,
    parameter int MOVE_CYCLES  = 4,
    parameter int PASS_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             entry_req,
    input  logic             entry_hc,
    input  logic             exit_req,
    input  logic             exit_hc,
    input  logic             pass_sensor,
    output logic             gate_open,
    output logic             entry_grant,
    output logic             exit_grant,
    output logic             entry_deny,
    output logic             timeout,
    output logic [CNT_W-1:0] reg_free,
    output logic [CNT_W-1:0] hc_free,
    output logic             lot_full,
    output logic             busy
);

    localparam int TMR_MAX = (PASS_TIMEOUT > MOVE_CYCLES) ? PASS_TIMEOUT : MOVE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic DIR_ENTRY = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        OPENING,
        WAIT_PASS,
        CLOSING
    } state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             gate_q, gate_d;
    logic             egrant_q, egrant_d;
    logic             xgrant_q, xgrant_d;
    logic             deny_q, deny_d;
    logic             tout_q, tout_d;
    logic [CNT_W-1:0] reg_q, reg_d;
    logic [CNT_W-1:0] hc_q, hc_d;
    logic             dir_q, dir_d;     // direction of the in-flight transaction
    logic             pool_q, pool_d;   // 1 = in-flight transaction uses hc pool
    logic             last_q, last_d;   // direction of the most recent grant

    // Entry eligibility: a permit holder prefers the hc pool and falls back
    // to the regular pool; everyone else may only use the regular pool.
    logic hc_ok, reg_ok, entry_ok, serve_entry;

    assign hc_ok    = entry_hc && (hc_q != '0);
    assign reg_ok   = (reg_q != '0);
    assign entry_ok = hc_ok || reg_ok;

    // Entry wins if it is alone, or on a conflict when exit went last.
    // An ineligible entry never wins, leaving the cycle free for exit.
    assign serve_entry = entry_req && entry_ok && (!exit_req || (last_q == DIR_EXIT));

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        gate_d   = gate_q;
        egrant_d = 1'b0;
        xgrant_d = 1'b0;
        deny_d   = 1'b0;
        tout_d   = 1'b0;
        reg_d    = reg_q;
        hc_d     = hc_q;
        dir_d    = dir_q;
        pool_d   = pool_q;
        last_d   = last_q;

        case (state_q)
            IDLE: begin
                deny_d = entry_req && !entry_ok;
                if (serve_entry) begin
                    state_d  = OPENING;
                    tmr_d    = '0;
                    gate_d   = 1'b1;
                    egrant_d = 1'b1;
                    dir_d    = DIR_ENTRY;
                    pool_d   = hc_ok;
                    last_d   = DIR_ENTRY;
                end else if (exit_req) begin
                    state_d  = OPENING;
                    tmr_d    = '0;
                    gate_d   = 1'b1;
                    xgrant_d = 1'b1;
                    dir_d    = DIR_EXIT;
                    pool_d   = exit_hc;
                    last_d   = DIR_EXIT;
                end
            end

            OPENING: begin
                if (tmr_q == TMR_W'(MOVE_CYCLES - 1)) begin
                    state_d = WAIT_PASS;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            WAIT_PASS: begin
                if (pass_sensor) begin
                    state_d = CLOSING;
                    tmr_d   = '0;
                    gate_d  = 1'b0;
                    // Guards keep counters from wrapping; a full-pool exit is dropped.
                    if (dir_q == DIR_ENTRY) begin
                        if (pool_q) begin
                            if (hc_q != '0) hc_d = hc_q - 1'b1;
                        end else begin
                            if (reg_q != '0) reg_d = reg_q - 1'b1;
                        end
                    end else begin
                        if (pool_q) begin
                            if (hc_q < CNT_W'(HC_SPACES)) hc_d = hc_q + 1'b1;
                        end else begin
                            if (reg_q < CNT_W'(REG_SPACES)) reg_d = reg_q + 1'b1;
                        end
                    end
                end else if (tmr_q == TMR_W'(PASS_TIMEOUT - 1)) begin
                    state_d = CLOSING;
                    tmr_d   = '0;
                    gate_d  = 1'b0;
                    tout_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            CLOSING: begin
                if (tmr_q == TMR_W'(MOVE_CYCLES - 1)) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                tmr_d   = '0;
                gate_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            gate_q   <= 1'b0;
            egrant_q <= 1'b0;
            xgrant_q <= 1'b0;
            deny_q   <= 1'b0;
            tout_q   <= 1'b0;
            reg_q    <= CNT_W'(REG_SPACES);
            hc_q     <= CNT_W'(HC_SPACES);
            dir_q    <= DIR_ENTRY;
            pool_q   <= 1'b0;
            last_q   <= DIR_ENTRY;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            gate_q   <= gate_d;
            egrant_q <= egrant_d;
            xgrant_q <= xgrant_d;
            deny_q   <= deny_d;
            tout_q   <= tout_d;
            reg_q    <= reg_d;
            hc_q     <= hc_d;
            dir_q    <= dir_d;
            pool_q   <= pool_d;
            last_q   <= last_d;
        end
    end

    assign gate_open   = gate_q;
    assign entry_grant = egrant_q;
    assign exit_grant  = xgrant_q;
    assign entry_deny  = deny_q;
    assign timeout     = tout_q;
    assign reg_free    = reg_q;
    assign hc_free     = hc_q;
    assign lot_full    = (reg_q == '0) && (hc_q == '0);
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_parking_gate_arbiter.sv
module tb_parking_gate_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       entry_req = 1'b0, entry_hc = 1'b0;
    logic       exit_req = 1'b0, exit_hc = 1'b0;
    logic       pass_sensor = 1'b0;
    logic       gate_open, entry_grant, exit_grant, entry_deny, timeout;
    logic [4:0] reg_free, hc_free;
    logic       lot_full, busy;

    int total = 0;
    int bad   = 0;

    parking_gate_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .entry_req   (entry_req),
        .entry_hc    (entry_hc),
        .exit_req    (exit_req),
        .exit_hc     (exit_hc),
        .pass_sensor (pass_sensor),
        .gate_open   (gate_open),
        .entry_grant (entry_grant),
        .exit_grant  (exit_grant),
        .entry_deny  (entry_deny),
        .timeout     (timeout),
        .reg_free    (reg_free),
        .hc_free     (hc_free),
        .lot_full    (lot_full),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        entry_req = 1'b0; exit_req = 1'b0; pass_sensor = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    // Raise a request in IDLE cycle t; returns at cycle t+1 with request dropped.
    task automatic start(input bit ent, input bit hc);
        if (ent) begin entry_req = 1'b1; entry_hc = hc; end
        else     begin exit_req  = 1'b1; exit_hc  = hc; end
        tick(1);
        entry_req = 1'b0;
        exit_req  = 1'b0;
    endtask

    // From cycle t+1: pulse pass k cycles into WAIT_PASS, return in next IDLE.
    task automatic pass_and_close(input int k);
        tick(4 + k);
        pass_sensor = 1'b1;
        tick(1);
        pass_sensor = 1'b0;
        tick(4);
    endtask

    task automatic txn(input bit ent, input bit hc);
        start(ent, hc);
        pass_and_close(0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got stuck want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. reset state and a plain entry
        do_reset();
        chk("rst_reg", reg_free, 20);
        chk("rst_hc", hc_free, 5);
        chk("rst_gate", gate_open, 0);
        chk("rst_busy", busy, 0);
        chk("rst_full", lot_full, 0);
        entry_req = 1'b1; entry_hc = 1'b0;
        tick(1);
        entry_req = 1'b0;
        chk("t1_grant", entry_grant, 1);
        chk("t1_gate_t1", gate_open, 1);
        chk("t1_busy", busy, 1);
        tick(1);
        chk("t1_grant_pulse", entry_grant, 0);
        tick(4);                       // t+6, second WAIT_PASS cycle
        chk("t1_gate_t6", gate_open, 1);
        pass_sensor = 1'b1;
        tick(1);                       // t+7, CLOSING
        pass_sensor = 1'b0;
        chk("t1_gate_t7", gate_open, 0);
        chk("t1_reg", reg_free, 19);
        tick(3);                       // t+10, last CLOSING cycle
        chk("t1_busy_t10", busy, 1);
        tick(1);
        chk("t1_busy_t11", busy, 0);

        // 2. pool selection and denial
        do_reset();
        repeat (5) txn(1'b1, 1'b1);
        chk("t2_hc0", hc_free, 0);
        chk("t2_reg20", reg_free, 20);
        repeat (17) txn(1'b1, 1'b0);
        chk("t2_reg3", reg_free, 3);
        txn(1'b1, 1'b1);
        chk("t2_hcfall_reg", reg_free, 2);
        chk("t2_hcfall_hc", hc_free, 0);
        repeat (2) txn(1'b1, 1'b0);
        chk("t2_full", lot_full, 1);
        entry_req = 1'b1; entry_hc = 1'b1;
        tick(1);
        chk("t2_deny", entry_deny, 1);
        chk("t2_nogrant", entry_grant, 0);
        chk("t2_idle", busy, 0);
        tick(1);
        chk("t2_deny_again", entry_deny, 1);
        entry_req = 1'b0;
        tick(1);
        chk("t2_deny_drop", entry_deny, 0);
        chk("t2_reg0", reg_free, 0);
        txn(1'b0, 1'b1);
        chk("t2_exit_hc", hc_free, 1);
        txn(1'b0, 1'b0);
        chk("t2_exit_reg", reg_free, 1);
        chk("t2_notfull", lot_full, 0);

        // 3. simultaneous requests from reset: exit first, then entry
        do_reset();
        entry_req = 1'b1; entry_hc = 1'b0;
        exit_req = 1'b1; exit_hc = 1'b0;
        tick(1);
        exit_req = 1'b0;
        chk("t3_xgrant", exit_grant, 1);
        chk("t3_no_egrant", entry_grant, 0);
        pass_and_close(0);             // t+10, IDLE, entry still held
        chk("t3_sat_reg", reg_free, 20);
        chk("t3_wait_egrant", entry_grant, 0);
        tick(1);                       // t+11
        entry_req = 1'b0;
        chk("t3_egrant", entry_grant, 1);
        pass_and_close(0);
        chk("t3_reg", reg_free, 19);

        // 4. no pass -> timeout
        do_reset();
        start(1'b1, 1'b0);             // t+1
        tick(19);                      // t+20, last WAIT_PASS cycle
        chk("t4_no_to_yet", timeout, 0);
        chk("t4_gate_hold", gate_open, 1);
        tick(1);                       // t+21
        chk("t4_timeout", timeout, 1);
        chk("t4_gate_fall", gate_open, 0);
        tick(1);
        chk("t4_to_pulse", timeout, 0);
        tick(2);                       // t+24
        chk("t4_busy24", busy, 1);
        tick(1);                       // t+25
        chk("t4_idle25", busy, 0);
        chk("t4_reg", reg_free, 20);

        // 5. hc exit at full hc pool saturates
        do_reset();
        start(1'b0, 1'b1);
        chk("t5_xgrant", exit_grant, 1);
        pass_and_close(0);
        chk("t5_hc", hc_free, 5);
        chk("t5_busy", busy, 0);
        chk("t5_gate", gate_open, 0);

        // 6. reset mid WAIT_PASS
        do_reset();
        txn(1'b1, 1'b0);
        chk("t6_pre", reg_free, 19);
        start(1'b1, 1'b0);
        tick(5);                       // t+6, in WAIT_PASS
        #2 reset_n = 1'b0;
        #1;
        chk("t6_gate", gate_open, 0);
        chk("t6_reg", reg_free, 20);
        chk("t6_hc", hc_free, 5);
        chk("t6_busy", busy, 0);
        tick(1);
        reset_n = 1'b1;
        pass_sensor = 1'b1;
        tick(1);
        pass_sensor = 1'b0;
        tick(1);
        chk("t6_nocommit", reg_free, 20);
        chk("t6_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
